icache_downstream_rxdat_responder: RTL and testbench



---
 rtl/icache_downstream_rxdat_responder_pkg.sv | 54 +++++
 rtl/icache_downstream_rxdat_responder_if.sv | 23 ++
 rtl/icache_rsp_req_fifo.sv | 55 +++++
 rtl/icache_downstream_rxdat_responder.sv | 115 +++++++++++
 tb/tb_icache_downstream_rxdat_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_downstream_rxdat_responder_pkg.sv
// Shared types, constants and the line-data pattern for the icache downstream responder.
// Sizes follow the icache line geometry: 64-byte lines, 512-bit data beats.
package icache_downstream_rxdat_responder_pkg;

    localparam int ICACHE_DATA_WIDTH      = 512;
    localparam int ICACHE_ADDR_WIDTH      = 32;
    localparam int ICACHE_REQ_TXNID_WIDTH = 4;
    localparam int MSHR_ENTRY_INDEX_WIDTH = 2;
    localparam int OPCODE_WIDTH           = 3;
    localparam int LINE_OFFSET_BITS       = $clog2(ICACHE_DATA_WIDTH / 8);
    localparam int LINE_WORDS             = ICACHE_DATA_WIDTH / 32;

    typedef logic [ICACHE_ADDR_WIDTH-1:0] addr_t;
    typedef logic [OPCODE_WIDTH-1:0]      opcode_t;

    localparam opcode_t DOWNSTREAM_RD_OPCODE = 3'd1;
    localparam opcode_t UPSTREAM_OPCODE      = 3'd4;

    typedef struct packed {
        addr_t                             addr;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
        logic                              lineA;
        opcode_t                           opcode;
    } downstream_txreq_t;

    // Data low half [W/2-1:0] feeds icache array A, high half feeds array B.
    typedef struct packed {
        logic [ICACHE_DATA_WIDTH-1:0]      downstream_rxdat_data;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] downstream_rxdat_txnid;
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
        logic                              lineA;
        opcode_t                           downstream_rxdat_opcode;
    } downstream_rxdat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } rsp_state_e;

    function automatic logic [ICACHE_DATA_WIDTH-1:0] gen_line_data(
        input logic [23:0] line_addr,
        input logic [31:0] seed
    );
        logic [ICACHE_DATA_WIDTH-1:0] data;
        data = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            data[w*32 +: 32] = {line_addr, 8'(w)} ^ seed;
        end
        return data;
    endfunction

endpackage

// File: rtl/icache_downstream_rxdat_responder_if.sv
// Request and line-data channels between the icache MSHR (master) and its downstream responder (slave).
interface icache_downstream_rxdat_responder_if;
    import icache_downstream_rxdat_responder_pkg::*;

    logic              downstream_txreq_vld;
    logic              downstream_txreq_rdy;
    downstream_txreq_t downstream_txreq_pld;
    logic              downstream_rxdat_vld;
    logic              downstream_rxdat_rdy;
    downstream_rxdat_t downstream_rxdat_pld;
    logic              rsp_busy;

    modport master (
        output downstream_txreq_vld, downstream_txreq_pld, downstream_rxdat_rdy,
        input  downstream_txreq_rdy, downstream_rxdat_vld, downstream_rxdat_pld, rsp_busy
    );

    modport slave (
        input  downstream_txreq_vld, downstream_txreq_pld, downstream_rxdat_rdy,
        output downstream_txreq_rdy, downstream_rxdat_vld, downstream_rxdat_pld, rsp_busy
    );

endinterface

// File: rtl/icache_rsp_req_fifo.sv
// Synchronous FIFO holding outstanding miss requests in arrival order.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
module icache_rsp_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int           AW        = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  PTR_ONE   = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DEPTH_CNT);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/icache_downstream_rxdat_responder.sv
// Memory stand-in for icache line fills: queues miss requests, waits RSP_LATENCY cycles,
// then returns one full line per request, strictly in order with one line outstanding.
module icache_downstream_rxdat_responder
    import icache_downstream_rxdat_responder_pkg::*;
#(
    parameter int          REQ_FIFO_DEPTH = 4,
    parameter int          RSP_LATENCY    = 8,
    parameter logic [31:0] DATA_SEED      = 32'h1CAC_0000
) (
    input logic                                clk,
    input logic                                rst_n,
    icache_downstream_rxdat_responder_if.slave bus
);

    localparam int         AW       = $clog2(REQ_FIFO_DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(RSP_LATENCY - 1);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    downstream_txreq_t head;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;
    logic              push_fire, pop_fire, more_after_pop;

    rsp_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              vld_q, vld_d;
    downstream_rxdat_t pld_q, pld_d;

    icache_rsp_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH),
        .WIDTH ($bits(downstream_txreq_t))
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_fire),
        .push_data (bus.downstream_txreq_pld),
        .pop       (pop_fire),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign push_fire      = bus.downstream_txreq_vld && !fifo_full;
    assign more_after_pop = (fifo_count > CNT_ONE) || push_fire;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        pld_d    = pld_q;
        pop_fire = 1'b0;
        case (state_q)
            // Starting on the push edge itself makes the first beat land exactly RSP_LATENCY cycles later.
            ST_IDLE: begin
                if (!fifo_empty || push_fire) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    pld_d.downstream_rxdat_data   = gen_line_data(head.addr[LINE_OFFSET_BITS +: 24], DATA_SEED);
                    pld_d.downstream_rxdat_txnid  = head.txnid;
                    pld_d.entry_idx               = head.entry_idx;
                    pld_d.lineA                   = head.lineA;
                    pld_d.downstream_rxdat_opcode = (head.opcode == DOWNSTREAM_RD_OPCODE) ? UPSTREAM_OPCODE
                                                                                        : head.opcode;
                    vld_d   = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SEND: begin
                if (bus.downstream_rxdat_rdy) begin
                    pop_fire = 1'b1;
                    vld_d    = 1'b0;
                    if (more_after_pop) begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            pld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            pld_q   <= pld_d;
        end
    end

    assign bus.downstream_txreq_rdy = !fifo_full;
    assign bus.downstream_rxdat_vld = vld_q;
    assign bus.downstream_rxdat_pld = pld_q;
    assign bus.rsp_busy             = !fifo_empty || (state_q != ST_IDLE);

    // Byte offset and bits above the 24-bit line address do not shape the data pattern.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{head.addr[LINE_OFFSET_BITS-1:0],
                                head.addr[ICACHE_ADDR_WIDTH-1:LINE_OFFSET_BITS+24]};

endmodule

// File: tb/tb_icache_downstream_rxdat_responder.sv
// Scoreboard bench: requests push expected lines, the rxdat monitor pops and compares on each handshake.
module tb_icache_downstream_rxdat_responder;
    import icache_downstream_rxdat_responder_pkg::*;

    localparam logic [31:0] SEED = 32'h1CAC_0000;
    localparam int          LAT  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_downstream_rxdat_responder_if b0 ();
    icache_downstream_rxdat_responder_if b1 ();

    icache_downstream_rxdat_responder #(
        .REQ_FIFO_DEPTH (4), .RSP_LATENCY (LAT), .DATA_SEED (SEED)
    ) dut (.clk (clk), .rst_n (rst_n), .bus (b0));

    icache_downstream_rxdat_responder #(
        .REQ_FIFO_DEPTH (4), .RSP_LATENCY (1), .DATA_SEED (SEED)
    ) dut1 (.clk (clk), .rst_n (rst_n), .bus (b1));

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    downstream_rxdat_t exp_q[$];
    int hs_edges[$];
    int rise_edges[$];
    int hs_count = 0;
    int bb_hs_base = 0;
    int bb_first_push = 0;
    bit auto_rdy = 1'b1;
    bit man_rdy = 1'b0;
    bit pend = 1'b0;
    bit vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic downstream_rxdat_t model_rsp(input downstream_txreq_t r);
        downstream_rxdat_t m;
        logic [23:0] la;
        la = r.addr[29:6];
        for (int w = 0; w < 16; w++) m.downstream_rxdat_data[w*32 +: 32] = {la, 8'(w)} ^ SEED;
        m.downstream_rxdat_txnid  = r.txnid;
        m.entry_idx               = r.entry_idx;
        m.lineA                   = r.lineA;
        m.downstream_rxdat_opcode = (r.opcode == DOWNSTREAM_RD_OPCODE) ? UPSTREAM_OPCODE : r.opcode;
        return m;
    endfunction

    // Models the icache's registered rdy and scores every handshake.
    always @(negedge clk) begin
        downstream_rxdat_t e;
        if (!rst_n) begin
            pend = 1'b0;
            vld_prev = 1'b0;
            b0.downstream_rxdat_rdy = 1'b0;
        end else begin
            b0.downstream_rxdat_rdy = auto_rdy ? pend : man_rdy;
            if (b0.downstream_rxdat_vld && !vld_prev) rise_edges.push_back(cyc);
            vld_prev = b0.downstream_rxdat_vld;
            if (b0.downstream_rxdat_vld && b0.downstream_rxdat_rdy) begin
                hs_count++;
                hs_edges.push_back(cyc + 1);
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_extra: got txnid %0d, required no response",
                             b0.downstream_rxdat_pld.downstream_rxdat_txnid);
                end else begin
                    e = exp_q.pop_front();
                    if (b0.downstream_rxdat_pld !== e) begin
                        tests_failed++;
                        $display("FAIL scoreboard_pld: got txnid %0d idx %0d lineA %0d op %0d w0 %h w15 %h, required txnid %0d idx %0d lineA %0d op %0d w0 %h w15 %h",
                                 b0.downstream_rxdat_pld.downstream_rxdat_txnid, b0.downstream_rxdat_pld.entry_idx,
                                 b0.downstream_rxdat_pld.lineA, b0.downstream_rxdat_pld.downstream_rxdat_opcode,
                                 b0.downstream_rxdat_pld.downstream_rxdat_data[31:0],
                                 b0.downstream_rxdat_pld.downstream_rxdat_data[511:480],
                                 e.downstream_rxdat_txnid, e.entry_idx, e.lineA, e.downstream_rxdat_opcode,
                                 e.downstream_rxdat_data[31:0], e.downstream_rxdat_data[511:480]);
                    end
                end
            end
            pend = b0.downstream_rxdat_vld && !(b0.downstream_rxdat_vld && b0.downstream_rxdat_rdy);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(input downstream_txreq_t r, output int push_edge);
        bit acc;
        acc = 1'b0;
        push_edge = -1;
        b0.downstream_txreq_vld = 1'b1;
        b0.downstream_txreq_pld = r;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = b0.downstream_txreq_rdy;
            step();
        end
        b0.downstream_txreq_vld = 1'b0;
        if (acc) begin
            push_edge = cyc;
            exp_q.push_back(model_rsp(r));
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: txnid %0d not accepted, required acceptance within 200 cycles", r.txnid);
        end
    endtask

    task automatic wait_vld(output int rise, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        rise = -1;
        while (!ok && n < 100) begin
            if (b0.downstream_rxdat_vld === 1'b1) begin
                ok = 1'b1;
                rise = cyc;
            end else begin
                step();
                n++;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL vld_timeout: rxdat_vld stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (b0.rsp_busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        tests_run++;
        if (b0.rsp_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_drain: rsp_busy %b after %0d cycles, required 0", name, b0.rsp_busy, n);
        end
    endtask

    function automatic downstream_txreq_t mk_req(input logic [31:0] a, input int t, input int idx,
                                                 input logic la, input opcode_t op);
        downstream_txreq_t r;
        r.addr = a;
        r.txnid = 4'(t);
        r.entry_idx = 2'(idx);
        r.lineA = la;
        r.opcode = op;
        return r;
    endfunction

    task automatic test_reset();
        repeat (3) step();
        tests_run += 6;
        if (b0.downstream_rxdat_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_vld: got %b, required 0", b0.downstream_rxdat_vld); end
        if (b0.downstream_rxdat_pld !== '0) begin tests_failed++; $display("FAIL reset_pld: got txnid %0d w0 %h, required all zero", b0.downstream_rxdat_pld.downstream_rxdat_txnid, b0.downstream_rxdat_pld.downstream_rxdat_data[31:0]); end
        if (b0.downstream_txreq_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy: got %b, required 1", b0.downstream_txreq_rdy); end
        if (b0.rsp_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", b0.rsp_busy); end
        if (b1.downstream_rxdat_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_vld_lat1: got %b, required 0", b1.downstream_rxdat_vld); end
        if (b1.downstream_txreq_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy_lat1: got %b, required 1", b1.downstream_txreq_rdy); end
        rst_n = 1'b1;
        repeat (2) step();
        tests_run += 2;
        if (b0.rsp_busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b, required 0", b0.rsp_busy); end
        if (b0.downstream_rxdat_vld !== 1'b0) begin tests_failed++; $display("FAIL post_reset_vld: got %b, required 0", b0.downstream_rxdat_vld); end
    endtask

    task automatic test_single();
        int p, rise, hi;
        bit ok;
        auto_rdy = 1'b1;
        push_req(mk_req(32'h0000_1040, 5, 2, 1'b1, DOWNSTREAM_RD_OPCODE), p);
        wait_vld(rise, ok);
        if (ok) begin
            tests_run += 5;
            if (rise - p != LAT) begin tests_failed++; $display("FAIL single_latency: got %0d cycles, required %0d", rise - p, LAT); end
            if (b0.downstream_rxdat_pld.downstream_rxdat_data[31:0] !== 32'h1CAC_4100) begin tests_failed++; $display("FAIL single_word0: got %h, required 1cac4100", b0.downstream_rxdat_pld.downstream_rxdat_data[31:0]); end
            if (b0.downstream_rxdat_pld.downstream_rxdat_txnid !== 4'd5) begin tests_failed++; $display("FAIL single_txnid: got %0d, required 5", b0.downstream_rxdat_pld.downstream_rxdat_txnid); end
            if (b0.downstream_rxdat_pld.entry_idx !== 2'd2 || b0.downstream_rxdat_pld.lineA !== 1'b1) begin tests_failed++; $display("FAIL single_idx_lineA: got %0d/%0d, required 2/1", b0.downstream_rxdat_pld.entry_idx, b0.downstream_rxdat_pld.lineA); end
            if (b0.downstream_rxdat_pld.downstream_rxdat_opcode !== UPSTREAM_OPCODE) begin tests_failed++; $display("FAIL single_opcode: got %0d, required %0d", b0.downstream_rxdat_pld.downstream_rxdat_opcode, UPSTREAM_OPCODE); end
            hi = 0;
            while (b0.downstream_rxdat_vld === 1'b1 && hi < 50) begin
                hi++;
                step();
            end
            tests_run++;
            if (hi != 2) begin tests_failed++; $display("FAIL single_vld_width: got %0d cycles high, required 2", hi); end
        end
        wait_idle("single");
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single_sb_empty: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int pe [4];
        int bad;
        hs_edges.delete();
        rise_edges.delete();
        bb_hs_base = hs_count;
        auto_rdy = 1'b1;
        for (int t = 0; t < 4; t++)
            push_req(mk_req(32'h0000_2000 + 32'(t * 64), t, t, 1'(t), (t == 2) ? 3'd2 : DOWNSTREAM_RD_OPCODE), pe[t]);
        bad = 0;
        for (int t = 1; t < 4; t++) if (pe[t] != pe[0] + t) bad++;
        bb_first_push = pe[0];
        tests_run += 2;
        if (bad != 0) begin tests_failed++; $display("FAIL b2b_consecutive: got %0d non-consecutive pushes, required 0", bad); end
        if (b0.downstream_txreq_rdy !== 1'b0) begin tests_failed++; $display("FAIL b2b_rdy_full: got %b, required 0", b0.downstream_txreq_rdy); end
    endtask

    task automatic test_full_boundary();
        int p5, bad;
        push_req(mk_req(32'h0000_2400, 4, 0, 1'b0, DOWNSTREAM_RD_OPCODE), p5);
        tests_run++;
        if (hs_edges.size() < 1 || p5 != hs_edges[0] + 1) begin
            tests_failed++;
            $display("FAIL full_push_edge: got accept at %0d, first pop at %0d, required pop+1",
                     p5, (hs_edges.size() > 0) ? hs_edges[0] : -1);
        end
        wait_idle("full");
        tests_run += 4;
        if (hs_count - bb_hs_base != 5) begin tests_failed++; $display("FAIL full_resp_count: got %0d, required 5", hs_count - bb_hs_base); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL full_sb_empty: got %0d pending, required 0", exp_q.size()); end
        if (rise_edges.size() < 1 || rise_edges[0] - bb_first_push != LAT) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d, required %0d", (rise_edges.size() > 0) ? rise_edges[0] - bb_first_push : -1, LAT); end
        bad = 0;
        if (rise_edges.size() != 5 || hs_edges.size() != 5) bad = 99;
        else for (int i = 1; i < 5; i++) if (rise_edges[i] - hs_edges[i-1] != LAT) bad++;
        if (bad != 0) begin tests_failed++; $display("FAIL b2b_spacing: got %0d bad gaps (rises %0d hs %0d), required 0", bad, rise_edges.size(), hs_edges.size()); end
    endtask

    task automatic test_backpressure();
        int p, rise, bad, h0;
        bit ok;
        downstream_rxdat_t snap;
        auto_rdy = 1'b0;
        man_rdy = 1'b0;
        h0 = hs_count;
        push_req(mk_req(32'h0000_ABC0, 9, 3, 1'b1, 3'd3), p);
        wait_vld(rise, ok);
        snap = b0.downstream_rxdat_pld;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (b0.downstream_rxdat_vld !== 1'b1 || b0.downstream_rxdat_pld !== snap) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", bad); end
        man_rdy = 1'b1;
        step();
        man_rdy = 1'b0;
        repeat (4) step();
        tests_run += 2;
        if (hs_count - h0 != 1) begin tests_failed++; $display("FAIL bp_handshakes: got %0d, required 1", hs_count - h0); end
        if (b0.downstream_rxdat_vld !== 1'b0 || b0.rsp_busy !== 1'b0) begin tests_failed++; $display("FAIL bp_after: got vld %b busy %b, required 0 0", b0.downstream_rxdat_vld, b0.rsp_busy); end
        auto_rdy = 1'b1;
    endtask

    task automatic test_reset_mid_send();
        int p, rise, h0, stale;
        bit ok;
        auto_rdy = 1'b0;
        man_rdy = 1'b0;
        for (int t = 0; t < 3; t++) push_req(mk_req(32'h0000_4000 + 32'(t * 64), 10 + t, t, 1'b0, DOWNSTREAM_RD_OPCODE), p);
        wait_vld(rise, ok);
        tests_run++;
        if (b0.rsp_busy !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_busy: got %b, required 1", b0.rsp_busy); end
        rst_n = 1'b0;
        #1;
        tests_run += 2;
        if (b0.downstream_rxdat_vld !== 1'b0) begin tests_failed++; $display("FAIL rst_async_vld: got %b, required 0", b0.downstream_rxdat_vld); end
        if (b0.rsp_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b, required 0", b0.rsp_busy); end
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        auto_rdy = 1'b1;
        step();
        tests_run += 2;
        if (b0.rsp_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_release_busy: got %b, required 0", b0.rsp_busy); end
        if (b0.downstream_txreq_rdy !== 1'b1) begin tests_failed++; $display("FAIL rst_release_rdy: got %b, required 1", b0.downstream_txreq_rdy); end
        h0 = hs_count;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (b0.downstream_rxdat_vld !== 1'b0) stale++;
        end
        tests_run++;
        if (stale != 0 || hs_count != h0) begin tests_failed++; $display("FAIL rst_stale: got %0d vld cycles %0d handshakes, required 0 0", stale, hs_count - h0); end
    endtask

    task automatic test_latency1();
        downstream_txreq_t r;
        downstream_rxdat_t e;
        r = mk_req(32'h0000_3000, 7, 1, 1'b0, DOWNSTREAM_RD_OPCODE);
        e = model_rsp(r);
        b1.downstream_rxdat_rdy = 1'b0;
        b1.downstream_txreq_pld = r;
        b1.downstream_txreq_vld = 1'b1;
        tests_run++;
        if (b1.downstream_txreq_rdy !== 1'b1) begin tests_failed++; $display("FAIL lat1_rdy: got %b, required 1", b1.downstream_txreq_rdy); end
        step();
        b1.downstream_txreq_vld = 1'b0;
        tests_run++;
        if (b1.downstream_rxdat_vld !== 1'b0) begin tests_failed++; $display("FAIL lat1_early: got vld %b on push edge, required 0", b1.downstream_rxdat_vld); end
        step();
        tests_run += 3;
        if (b1.downstream_rxdat_vld !== 1'b1) begin tests_failed++; $display("FAIL lat1_vld: got %b one cycle after push, required 1", b1.downstream_rxdat_vld); end
        if (b1.downstream_rxdat_pld.lineA !== 1'b0) begin tests_failed++; $display("FAIL lat1_lineA: got %b, required 0", b1.downstream_rxdat_pld.lineA); end
        if (b1.downstream_rxdat_pld !== e) begin tests_failed++; $display("FAIL lat1_pld: got txnid %0d w0 %h, required txnid %0d w0 %h", b1.downstream_rxdat_pld.downstream_rxdat_txnid, b1.downstream_rxdat_pld.downstream_rxdat_data[31:0], e.downstream_rxdat_txnid, e.downstream_rxdat_data[31:0]); end
        b1.downstream_rxdat_rdy = 1'b1;
        step();
        b1.downstream_rxdat_rdy = 1'b0;
        step();
        tests_run++;
        if (b1.downstream_rxdat_vld !== 1'b0 || b1.rsp_busy !== 1'b0) begin tests_failed++; $display("FAIL lat1_done: got vld %b busy %b, required 0 0", b1.downstream_rxdat_vld, b1.rsp_busy); end
    endtask

    initial begin
        b0.downstream_txreq_vld = 1'b0;
        b0.downstream_txreq_pld = '0;
        b1.downstream_txreq_vld = 1'b0;
        b1.downstream_txreq_pld = '0;
        b1.downstream_rxdat_rdy = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_boundary();
        test_backpressure();
        test_reset_mid_send();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
